cnn_layer_accel_awe_stride_expander: RTL
========================================

CNN_LAYER_ACCEL_AWE_STRIDE_EXPANDER -- requirements
Module: cnn_layer_accel_awe_stride_expander

Interface
REQ-001 SHALL have parameter C_DATAIN_WIDTH, default 16, sample width in bits.
REQ-002 SHALL have parameter C_ROW_LEN_WIDTH, default 10, width of the input row-length field.
REQ-003 SHALL define C_STRIDE_COUNTER_WIDTH = $clog2(`MAX_STRIDE) locally.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port config_valid, input, 1, loads stride_size and row_length.
REQ-007 SHALL have port stride_size, input, C_STRIDE_COUNTER_WIDTH, number of zeros inserted after each sample and zero rows after each row.
REQ-008 SHALL have port row_length, input, C_ROW_LEN_WIDTH, input samples per row.
REQ-009 SHALL have port datain, input, C_DATAIN_WIDTH, input sample.
REQ-010 SHALL have port datain_valid, input, 1, datain qualifier.
REQ-011 SHALL have port datain_ready, output, 1, block accepts datain this cycle.
REQ-012 SHALL have port dataout, output, C_DATAIN_WIDTH, expanded stream sample (registered).
REQ-013 SHALL have port dataout_valid, output, 1, dataout qualifier.
REQ-014 SHALL have port dataout_ready, input, 1, downstream accepts dataout.

Function
REQ-015 SHALL implement the inverse of the stride picker: per input sample S emit S followed by stride_size zeros; after every complete input row emit stride_size zero rows of row_length*(stride_size+1) zeros each.
REQ-016 SHALL use states IDLE, SAMPLE, ZERO_COL, ZERO_ROW.
REQ-017 SHALL go IDLE->SAMPLE on config_valid with row_length!=0; with row_length==0, remain in/return to IDLE.
REQ-018 SHALL, in SAMPLE, assert datain_ready iff dataout_valid==0 or dataout_ready==1; on datain_valid&&datain_ready register datain to dataout with dataout_valid=1 next cycle.
REQ-019 SHALL go SAMPLE->ZERO_COL after an accepted sample when stride_size!=0; else stay in SAMPLE or go to ZERO_ROW at end of row.
REQ-020 SHALL, in ZERO_COL, emit exactly stride_size zeros, advancing one per output handshake, then return to SAMPLE or, at end of row, go to ZERO_ROW.
REQ-021 SHALL, in ZERO_ROW, emit stride_size*row_length*(stride_size+1) zeros using nested counters (no multiplier), then return to SAMPLE with the row counter cleared.
REQ-022 SHALL hold dataout/dataout_valid stable while dataout_valid==1 and dataout_ready==0.
REQ-023 SHALL deassert datain_ready in IDLE, ZERO_COL, ZERO_ROW.
REQ-024 SHALL sustain one output per cycle under continuous dataout_ready (zero-bubble transitions).
REQ-025 SHALL pass input unchanged (1:1, latency 1 cycle) when stride_size==0.
REQ-026 SHALL, on config_valid in any state, abort the current frame: clear counters and dataout_valid, load new config, go per REQ-017; config_valid takes priority over a simultaneous datain handshake (sample dropped).
REQ-027 SHALL wrap the sample-in-row counter at row_length.

Reset
REQ-028 SHALL on rst force state=IDLE, dataout_valid=0, dataout=0, datain_ready=0, all counters=0, stored stride/row_length=0.
REQ-029 SHALL on rst mid-frame discard all pending output; rst overrides config_valid.

Configuration
REQ-030 SHALL use macro AWE_STRIDE_EXPANDER_ZERO_ROW_EN: defined -> ZERO_ROW state and row counters compiled in per REQ-021; undefined -> ZERO_ROW logic absent, only column zeros inserted, row_length ignored except the ==0 check.

Verification
REQ-031 SHALL cover: stride=1,row_length=2, in A,B,C,D, ready=1 -> out A,0,B,0,0,0,0,0,C,0,D,0,0,0,0,0 on consecutive cycles.
REQ-032 SHALL cover: stride=0,row_length=4, in 1..8 -> out 1..8, latency 1, datain_ready constantly 1.
REQ-033 SHALL cover: stride=2, dataout_ready toggled 1/0 every cycle -> dataout stable during stalls, per-sample sequence S,0,0 intact, no loss.
REQ-034 SHALL cover: config_valid (stride=1) during ZERO_ROW of a stride=3 frame -> dataout_valid=0 next cycle, state SAMPLE, next input X yields X,0.
REQ-035 SHALL cover: rst asserted during ZERO_COL -> next cycle dataout_valid=0, datain_ready=0; after config, normal operation.
REQ-036 SHALL cover: macro undefined, stride=1,row_length=2, in A,B,C,D -> out A,0,B,0,C,0,D,0.

Source files
------------

// File: rtl/cnn_layer_accel_awe_stride_expander.sv
// cnn_layer_accel_awe_stride_expander
//
// Inverse of the stride picker. Each accepted input sample is followed by
// stride_size zero samples. When AWE_STRIDE_EXPANDER_ZERO_ROW_EN is defined,
// every complete input row is also followed by stride_size zero rows of
// row_length*(stride_size+1) zeros. When the macro is undefined only the
// column zeros are inserted and row_length matters only for the ==0 check
// and the sample-in-row wrap.
//
// Output is a single registered slot (dataout/dataout_valid) under a
// valid/ready handshake. A new value loads whenever the slot is empty or
// is being consumed, so transitions between states add no bubbles.
//
// MAX_STRIDE (a global define) bounds stride_size. It defaults to 8 when the
// build does not provide it.

`ifndef MAX_STRIDE
`define MAX_STRIDE 8
`endif

module cnn_layer_accel_awe_stride_expander #(
  parameter int C_DATAIN_WIDTH  = 16,
  parameter int C_ROW_LEN_WIDTH = 10,
  localparam int C_STRIDE_COUNTER_WIDTH = $clog2(`MAX_STRIDE)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              config_valid,
  input  logic [C_STRIDE_COUNTER_WIDTH-1:0] stride_size,
  input  logic [C_ROW_LEN_WIDTH-1:0]        row_length,
  input  logic [C_DATAIN_WIDTH-1:0]         datain,
  input  logic                              datain_valid,
  output logic                              datain_ready,
  output logic [C_DATAIN_WIDTH-1:0]         dataout,
  output logic                              dataout_valid,
  input  logic                              dataout_ready
);

  localparam logic [C_STRIDE_COUNTER_WIDTH-1:0] STRIDE_ONE = C_STRIDE_COUNTER_WIDTH'(1);
  localparam logic [C_ROW_LEN_WIDTH-1:0]        ROW_ONE    = C_ROW_LEN_WIDTH'(1);

`ifdef AWE_STRIDE_EXPANDER_ZERO_ROW_EN
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SAMPLE   = 2'd1,
    ZERO_COL = 2'd2,
    ZERO_ROW = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SAMPLE   = 2'd1,
    ZERO_COL = 2'd2
  } state_t;
`endif

  // Registered state and its next-value companions.
  state_t                            state_q,    state_d;
  logic [C_DATAIN_WIDTH-1:0]         dout_q,     dout_d;
  logic                              dvld_q,     dvld_d;
  logic [C_STRIDE_COUNTER_WIDTH-1:0] stride_q,   stride_d;
  logic [C_ROW_LEN_WIDTH-1:0]        rowlen_q,   rowlen_d;
  // Position of the next input sample within its row. During a zero row
  // it is reused as the sample-slot index inside that zero row.
  logic [C_ROW_LEN_WIDTH-1:0]        samp_cnt_q, samp_cnt_d;
  // Zeros emitted for the current sample. During a zero row it is reused
  // as the sub-position (0..stride) inside one expanded sample slot.
  logic [C_STRIDE_COUNTER_WIDTH-1:0] zcnt_q,     zcnt_d;
`ifdef AWE_STRIDE_EXPANDER_ZERO_ROW_EN
  // Set when the sample that started the current ZERO_COL burst closed a row.
  logic                              row_end_q,  row_end_d;
  // Zero rows already emitted after the current input row.
  logic [C_STRIDE_COUNTER_WIDTH-1:0] zrow_cnt_q, zrow_cnt_d;
`endif

  logic can_load;
  logic in_ready;
  logic last_in_row;

  // The output slot can take a new value when it is empty or being drained.
  assign can_load = !dvld_q || dataout_ready;

  assign datain_ready  = in_ready && !rst;
  assign dataout       = dout_q;
  assign dataout_valid = dvld_q;

  // Next-state and datapath: what to load into the output slot this cycle.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d     = state_q;
    dout_d      = dout_q;
    dvld_d      = dvld_q;
    stride_d    = stride_q;
    rowlen_d    = rowlen_q;
    samp_cnt_d  = samp_cnt_q;
    zcnt_d      = zcnt_q;
`ifdef AWE_STRIDE_EXPANDER_ZERO_ROW_EN
    row_end_d   = row_end_q;
    zrow_cnt_d  = zrow_cnt_q;
`endif
    in_ready    = 1'b0;
    last_in_row = (samp_cnt_q == rowlen_q - ROW_ONE);

    // A consumed output empties the slot unless something refills it below.
    if (dvld_q && dataout_ready) begin
      dvld_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Waiting for a usable configuration; input stays blocked.
      end

      SAMPLE: begin
        in_ready = can_load;
        if (datain_valid && can_load) begin
          dout_d     = datain;
          dvld_d     = 1'b1;
          samp_cnt_d = last_in_row ? '0 : samp_cnt_q + ROW_ONE;
          // With stride 0 there are no column or row zeros: pure pass-through.
          if (stride_q != '0) begin
            state_d = ZERO_COL;
            zcnt_d  = '0;
`ifdef AWE_STRIDE_EXPANDER_ZERO_ROW_EN
            row_end_d = last_in_row;
`endif
          end
        end
      end

      ZERO_COL: begin
        if (can_load) begin
          dout_d = '0;
          dvld_d = 1'b1;
          if (zcnt_q == stride_q - STRIDE_ONE) begin
            zcnt_d = '0;
`ifdef AWE_STRIDE_EXPANDER_ZERO_ROW_EN
            row_end_d = 1'b0;
            state_d   = row_end_q ? ZERO_ROW : SAMPLE;
`else
            state_d   = SAMPLE;
`endif
          end else begin
            zcnt_d = zcnt_q + STRIDE_ONE;
          end
        end
      end

`ifdef AWE_STRIDE_EXPANDER_ZERO_ROW_EN
      ZERO_ROW: begin
        // Three nested counters walk stride rows x row_length slots x
        // (stride+1) positions, so no multiplier is needed for the length.
        if (can_load) begin
          dout_d = '0;
          dvld_d = 1'b1;
          if (zcnt_q == stride_q) begin
            zcnt_d = '0;
            if (last_in_row) begin
              samp_cnt_d = '0;
              if (zrow_cnt_q == stride_q - STRIDE_ONE) begin
                zrow_cnt_d = '0;
                state_d    = SAMPLE;
              end else begin
                zrow_cnt_d = zrow_cnt_q + STRIDE_ONE;
              end
            end else begin
              samp_cnt_d = samp_cnt_q + ROW_ONE;
            end
          end else begin
            zcnt_d = zcnt_q + STRIDE_ONE;
          end
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

    // A new configuration aborts the frame in any state; an input handshake
    // in the same cycle is dropped.
    if (config_valid) begin
      stride_d   = stride_size;
      rowlen_d   = row_length;
      samp_cnt_d = '0;
      zcnt_d     = '0;
`ifdef AWE_STRIDE_EXPANDER_ZERO_ROW_EN
      row_end_d  = 1'b0;
      zrow_cnt_d = '0;
`endif
      dout_d     = '0;
      dvld_d     = 1'b0;
      state_d    = (row_length != '0) ? SAMPLE : IDLE;
    end
  end

  // State register with synchronous reset; reset overrides config_valid.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (rst) begin
      state_q    <= IDLE;
      dout_q     <= '0;
      dvld_q     <= 1'b0;
      stride_q   <= '0;
      rowlen_q   <= '0;
      samp_cnt_q <= '0;
      zcnt_q     <= '0;
`ifdef AWE_STRIDE_EXPANDER_ZERO_ROW_EN
      row_end_q  <= 1'b0;
      zrow_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dout_q     <= dout_d;
      dvld_q     <= dvld_d;
      stride_q   <= stride_d;
      rowlen_q   <= rowlen_d;
      samp_cnt_q <= samp_cnt_d;
      zcnt_q     <= zcnt_d;
`ifdef AWE_STRIDE_EXPANDER_ZERO_ROW_EN
      row_end_q  <= row_end_d;
      zrow_cnt_q <= zrow_cnt_d;
`endif
    end
  end

endmodule
